instr_encoder_loader: RTL and testbench

- Encoder counterpart to the opcode control decoder.
- Accepts symbolic instructions (mnemonic plus fields) over a valid/ready handshake.
- Encodes each into a 32-bit instruction word, using the same opcode map the decoder recognises.
- Writes the words sequentially into instruction memory through an acknowledged write port; used by benches and boot logic to load programs.

---
 rtl/instr_encoder_loader.sv | 128 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic instructions into 32-bit words and writes them sequentially to instruction memory
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   start                   begin a load session at BASE_ADDR (ignored while busy)
//   in_valid/in_ready       instruction-field handshake
//   in_mnem, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target, in_last
//                           symbolic instruction fields; in_last ends the session
//   mem_we/mem_ack          write request held until acknowledged
//   mem_addr, mem_wdata     write address and encoded word
//   busy, done, err, count  session status, completion pulse, sticky error, words written
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d, last_q, last_d;
    logic [5:0]        op;
    logic              legal;
    logic [31:0]       enc;
    always_comb begin
        legal = 1'b1;
        op    = 6'b000000;
        case (in_mnem)
            4'd0:    op = 6'b000000;
            4'd1:    op = 6'b100011;
            4'd2:    op = 6'b101011;
            4'd3:    op = 6'b000100;
            4'd4:    op = 6'b010101;
            4'd5:    op = 6'b010111;
            4'd6:    op = 6'b011001;
            4'd7:    op = 6'b101101;
            4'd8:    op = 6'b000111;
            4'd9:    op = 6'b000011;
            4'd10:   op = 6'b001101;
            default: legal = 1'b0;
        endcase
        enc = (in_mnem == 4'd0) ? {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct} :
              (in_mnem == 4'd9) ? {op, in_target} : {op, in_rs, in_rt, in_imm};
    end
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        last_d  = last_q;
        case (state_q)
            IDLE, ERR: if (start) begin
                state_d = LOAD;
                err_d   = 1'b0;
                count_d = '0;
                addr_d  = BASE;
            end
            LOAD: if (in_valid) begin
                if (legal) begin
                    wdata_d = enc;
                    last_d  = in_last;
                    state_d = WRITE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            WRITE: if (mem_ack) begin
                count_d = count_q + 1'b1;
                addr_d  = addr_q + 1'b1;
                // the last instruction wins even if it filled the final address
                state_d = last_q ? DONE : (&addr_q ? ERR : LOAD);
                err_d   = (!last_q && &addr_q) ? 1'b1 : err_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= BASE;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end
    // outputs decode straight from the state register so reset clears them without a clock
    assign in_ready  = state_q == LOAD;
    assign mem_we    = state_q == WRITE;
    assign busy      = state_q == LOAD || state_q == WRITE;
    assign done      = state_q == DONE;
    assign err       = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: table-driven, scoreboarded bench for instr_encoder_loader
module tb_instr_encoder_loader;
    localparam int AW = 8;
    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, mem_ack = 1'b0;
    logic [3:0] in_mnem = '0;
    logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0] in_funct = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic in_ready, mem_we, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [AW:0] count;
    logic start2 = 1'b0, in_valid2 = 1'b0, mem_ack2 = 1'b0;
    logic in_ready2, mem_we2, busy2, done2, err2;
    logic [1:0] mem_addr2;
    logic [31:0] mem_wdata2;
    logic [2:0] count2;

    instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err(err), .count(count));

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(1'b0),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ack(mem_ack2),
        .busy(busy2), .done(done2), .err(err2), .count(count2));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mn;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
        int          dly;
        logic [31:0] word;
    } vec_t;
    vec_t tv[12];

    int tests = 0, fails = 0, cyc = 0;
    int ack_dly = 0, hold = 0, wr_cnt = 0, done_cnt = 0, last_acc = 0;
    int acc[12];
    logic [AW-1:0] exp_addr = '0, cap_a;
    logic [31:0] cap_d;
    logic [AW+31:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // memory model: acks after ack_dly cycles, checks hold stability and pops the scoreboard
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_we) begin
            chk("ready_low_in_write", in_ready, 0);
            if (hold == 0) begin
                cap_a = mem_addr;
                cap_d = mem_wdata;
            end else begin
                chk("addr_hold", mem_addr, cap_a);
                chk("data_hold", mem_wdata, cap_d);
            end
            if (hold == ack_dly) begin
                mem_ack = 1'b1;
                wr_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h", mem_addr, mem_wdata);
                end else begin
                    logic [AW+31:0] e;
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_wdata} !== e) begin
                        fails++;
                        $display("FAIL write: got %0h:%0h expected %0h:%0h", mem_addr, mem_wdata, e[AW+31:32], e[31:0]);
                    end
                end
            end else mem_ack = 1'b0;
            hold++;
        end else begin
            hold = 0;
            mem_ack = 1'b0;
        end
    end

    task automatic set_fields(input vec_t v);
        in_mnem = v.mn; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_shamt = v.sh;
        in_funct = v.fn; in_imm = v.imm; in_target = v.tgt; in_last = v.last;
    endtask

    task automatic send(input vec_t v, input bit push);
        int t;
        set_fields(v);
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready %0b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        ack_dly = v.dly;
        if (push) begin
            exp_q.push_back({exp_addr, v.word});
            exp_addr++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        exp_addr = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int t;
        //          mn     rs     rt     rd     sh     fn      imm       tgt         last dly word
        tv[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'hFFFF, 26'h3FFFFFF, 1'b0, 0, 32'h00221820};
        tv[1]  = '{4'd1,  5'd4,  5'd5,  5'd31, 5'd31, 6'h3F, 16'h0010, 26'h0,       1'b0, 3, 32'h8C850010};
        tv[2]  = '{4'd2,  5'd3,  5'd7,  5'd0,  5'd0,  6'h00, 16'h1234, 26'h0,       1'b0, 1, 32'hAC671234};
        tv[3]  = '{4'd3,  5'd31, 5'd31, 5'd0,  5'd0,  6'h00, 16'hABCD, 26'h0,       1'b0, 0, 32'h13FFABCD};
        tv[4]  = '{4'd4,  5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0001, 26'h0,       1'b0, 0, 32'h54000001};
        tv[5]  = '{4'd5,  5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0002, 26'h0,       1'b0, 0, 32'h5C000002};
        tv[6]  = '{4'd6,  5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0003, 26'h0,       1'b0, 0, 32'h64000003};
        tv[7]  = '{4'd8,  5'd2,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0,       1'b0, 0, 32'h1C400000};
        tv[8]  = '{4'd0,  5'd0,  5'd0,  5'd0,  5'd5,  6'h02, 16'h0000, 26'h0,       1'b1, 2, 32'h00000142};
        tv[9]  = '{4'd7,  5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFE, 26'h0,       1'b0, 0, 32'hB422FFFE};
        tv[10] = '{4'd10, 5'd0,  5'd8,  5'd0,  5'd0,  6'h00, 16'h00FF, 26'h0,       1'b0, 0, 32'h340800FF};
        tv[11] = '{4'd9,  5'd31, 5'd31, 5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h40,      1'b1, 0, 32'h0C000040};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_count", count, 0);
        reset = 1'b0;
        @(negedge clk);

        do_start();
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, 1);
        for (int i = 0; i < 9; i++) begin
            send(tv[i], 1'b1);
            acc[i] = last_acc;
        end
        chk("throughput_zero_wait", acc[1] - acc[0], 2);
        chk("throughput_ack_delay3", acc[2] - acc[1], 5);
        repeat (10) @(negedge clk);
        chk("sessA_done_pulses", done_cnt, 1);
        chk("sessA_count", count, 9);
        chk("sessA_addr", mem_addr, 9);
        chk("sessA_busy", busy, 0);
        chk("sessA_pending", exp_q.size(), 0);

        do_start();
        for (int i = 9; i < 12; i++) send(tv[i], 1'b1);
        repeat (6) @(negedge clk);
        chk("sessB_done_pulses", done_cnt, 2);
        chk("sessB_count", count, 3);
        chk("sessB_addr", mem_addr, 3);
        chk("sessB_err", err, 0);

        do_start();
        send(tv[0], 1'b1);
        v = tv[3];
        v.mn = 4'd12;
        send(v, 1'b0);
        chk("illegal_err", err, 1);
        chk("illegal_busy", busy, 0);
        chk("illegal_ready", in_ready, 0);
        t = wr_cnt;
        set_fields(tv[4]);
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        chk("err_no_write", wr_cnt, t);
        chk("err_count", count, 1);
        chk("err_sticky", err, 1);
        do_start();
        chk("restart_err_clear", err, 0);
        chk("restart_count", count, 0);
        chk("restart_addr", mem_addr, 0);
        chk("restart_ready", in_ready, 1);
        send(tv[11], 1'b1);
        repeat (5) @(negedge clk);
        chk("restart_done", done_cnt, 3);
        chk("restart_final_count", count, 1);

        do_start();
        v = tv[1];
        v.dly = 100;
        send(v, 1'b1);
        @(negedge clk);
        chk("pre_reset_we", mem_we, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_we", mem_we, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_wdata", mem_wdata, 0);
        chk("async_rst_addr", mem_addr, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        ack_dly = 0;
        @(negedge clk);

        set_fields(tv[10]);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid2 = 1'b1;
            t = 0;
            while (!in_ready2 && t < 20) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
            in_valid2 = 1'b0;
            chk("small_we", mem_we2, 1);
            chk("small_addr", mem_addr2, i);
            chk("small_data", mem_wdata2, 32'h340800FF);
            mem_ack2 = 1'b1;
            @(negedge clk);
            mem_ack2 = 1'b0;
        end
        chk("full_err", err2, 1);
        chk("full_count", count2, 4);
        chk("full_busy", busy2, 0);
        in_valid2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("full_ready_low", in_ready2, 0);
            chk("full_no_we", mem_we2, 0);
            @(negedge clk);
        end
        in_valid2 = 1'b0;
        chk("full_count_final", count2, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
